button_conditioner: RTL



---
 rtl/button_conditioner.sv | 122 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Four-channel pushbutton front end: 2-flop synchroniser, debounce, and registered
// press/release/auto-repeat pulses. Bit order is [0]=left [1]=right [2]=up [3]=down.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       leftbtn,
  input  logic       rightbtn,
  input  logic       upbtn,
  input  logic       downbtn,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_repeat,
  output logic       any_press
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] RD_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RR_LAST = REP_W'(REPEAT_RATE - 1);

  logic [3:0] raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] stable_q, stable_d;
  logic [3:0] press_q, press_d;
  logic [3:0] release_q, release_d;
  logic [3:0] repeat_q, repeat_d;
  logic [3:0] repeating_q, repeating_d;
  logic       any_q, any_d;
  logic [DB_W-1:0]  db_cnt_q  [4];
  logic [DB_W-1:0]  db_cnt_d  [4];
  logic [REP_W-1:0] rep_cnt_q [4];
  logic [REP_W-1:0] rep_cnt_d [4];

  assign raw = {downbtn, upbtn, rightbtn, leftbtn};

  always_comb begin
    sync1_d     = raw;
    sync2_d     = sync1_q;
    stable_d    = stable_q;
    press_d     = '0;
    release_d   = '0;
    repeat_d    = '0;
    repeating_d = repeating_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i]  = db_cnt_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
    end

    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        stable_d[i]  = sync2_q[i];
        db_cnt_d[i]  = '0;
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end

      // repeating_q selects the initial delay versus the steady repeat period
      if (!stable_q[i] || release_d[i]) begin
        rep_cnt_d[i]   = '0;
        repeating_d[i] = 1'b0;
      end else if (rep_cnt_q[i] == (repeating_q[i] ? RR_LAST : RD_LAST)) begin
        repeat_d[i]    = 1'b1;
        rep_cnt_d[i]   = '0;
        repeating_d[i] = 1'b1;
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
      end
    end

    any_d = |press_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      press_q     <= '0;
      release_q   <= '0;
      repeat_q    <= '0;
      repeating_q <= '0;
      any_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i]  <= '0;
        rep_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      repeating_q <= repeating_d;
      any_q       <= any_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end

  assign btn_level   = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;
  assign any_press   = any_q;

endmodule
